// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of (pc_next, instruction)
// pairs with valid/ready output and fetch throttling via pc_en.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_pc_next,
  input  logic [31:0]   in_instruction,
  output logic          pc_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc_next,
  output logic [31:0]   out_instruction,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign full      = (count == CW'(DEPTH));
  assign pc_en     = rst & ~full;
  assign out_valid = (count != '0);
  assign push      = in_valid & pc_en;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  // Empty queue reads as zero, which is a NOP for decode.
  assign out_pc_next     = out_valid ? head[63:32] : 32'h0;
  assign out_instruction = out_valid ? head[31:0]  : 32'h0;

  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      mem[wr_ptr] <= {in_pc_next, in_instruction};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_pc_next;
  logic [31:0]   in_instruction;
  logic          pc_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc_next;
  logic [31:0]   out_instruction;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_pc_next(in_pc_next),
    .in_instruction(in_instruction),
    .pc_en(pc_en),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc_next(out_pc_next),
    .out_instruction(out_instruction),
    .count(count)
  );

  int total  = 0;
  int passed = 0;

  logic [63:0] mq[$];

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        rdy;
    logic [31:0] e_cnt;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_en;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock; the model consumes the inputs seen before the edge.
  task automatic step();
    bit clr;
    bit m_push;
    bit m_pop;
    clr    = !rst || flush;
    m_push = in_valid && (mq.size() < DEPTH);
    m_pop  = out_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (clr) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_pc_next, in_instruction});
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    e_pc  = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
    e_ins = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, "_pc"}, out_pc_next, e_pc);
    chk({tag, "_ins"}, out_instruction, e_ins);
    chk({tag, "_pc_en"}, 32'(pc_en), 32'(rst && (mq.size() != DEPTH)));
    chk({tag, "_bound"}, 32'(count <= CW'(DEPTH)), 32'd1);
  endtask

  initial begin
    int pops;
    int pushed;
    int cyc;
    int pat[5];
    bit tk;
    bit acc;
    logic [31:0] exp_pc;
    logic [31:0] nxt;

    pat = '{1, 0, 1, 1, 0};
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc_next = '0;
    in_instruction = '0;
    flush = 1'b0;
    out_ready = 1'b0;

    // rst iv pc ins fl rdy | cnt val pc ins pc_en
    tv[0] = '{1'b0, 1'b1, 32'd4, 32'h20080001, 1'b0, 1'b0,
              0, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 32'd4, 32'h20080001, 1'b0, 1'b0,
              0, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1,
              0, 1'b0, 32'h0, 32'h0, 1'b1};
    tv[3] = '{1'b1, 1'b1, 32'd4, 32'h20080001, 1'b0, 1'b1,
              1, 1'b1, 32'd4, 32'h20080001, 1'b1};
    tv[4] = '{1'b1, 1'b1, 32'd8, 32'h20090002, 1'b0, 1'b1,
              1, 1'b1, 32'd8, 32'h20090002, 1'b1};
    tv[5] = '{1'b1, 1'b1, 32'd12, 32'h012A4020, 1'b0, 1'b1,
              1, 1'b1, 32'd12, 32'h012A4020, 1'b1};
    tv[6] = '{1'b1, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1,
              0, 1'b0, 32'h0, 32'h0, 1'b1};

    for (int i = 0; i < 7; i++) begin
      rst = tv[i].rst;
      in_valid = tv[i].iv;
      in_pc_next = tv[i].pc;
      in_instruction = tv[i].ins;
      flush = tv[i].fl;
      out_ready = tv[i].rdy;
      step();
      chk($sformatf("tv%0d_count", i), 32'(count), tv[i].e_cnt);
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tv[i].e_val));
      chk($sformatf("tv%0d_pc", i), out_pc_next, tv[i].e_pc);
      chk($sformatf("tv%0d_ins", i), out_instruction, tv[i].e_ins);
      chk($sformatf("tv%0d_pc_en", i), 32'(pc_en), 32'(tv[i].e_en));
    end

    // Fill and drain
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc_next = 32'(4 + 4 * i);
      in_instruction = 32'hA000_0000 + 32'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_pc_en", 32'(pc_en), 32'd0);
    in_pc_next = 32'd20;
    in_instruction = 32'hA000_0004;
    step();
    chk("held_count", 32'(count), 32'd4);
    chk("held_pc_en", 32'(pc_en), 32'd0);
    chk("drain_pc0", out_pc_next, 32'd4);
    out_ready = 1'b1;
    step();
    chk("pulse_count", 32'(count), 32'd3);
    chk("pulse_pc_en", 32'(pc_en), 32'd1);
    out_ready = 1'b0;
    step();
    chk("accept5_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("drain_pc", out_pc_next, 32'(4 + 4 * i));
      chk("drain_ins", out_instruction, 32'hA000_0000 + 32'(i));
      step();
    end
    chk("drain_empty", 32'(count), 32'd0);

    // Wrap with toggling out_ready
    pops = 0;
    pushed = 0;
    cyc = 0;
    exp_pc = 32'h200;
    nxt = 32'h200;
    while (pops < 10 && cyc < 80) begin
      out_ready = pat[cyc % 5][0];
      in_valid = (pushed < 10);
      in_pc_next = nxt;
      in_instruction = nxt ^ 32'hABCD_0000;
      #1;
      acc = in_valid && pc_en;
      tk = out_valid && out_ready;
      if (tk) begin
        chk("wrap_order", out_pc_next, exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      step();
      check_model("wrap");
      if (acc) begin
        nxt = nxt + 32'd4;
        pushed++;
      end
      cyc++;
    end
    chk("wrap_pops", 32'(pops), 32'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("wrap_empty", 32'(count), 32'd0);

    // Flush with simultaneous push and pop
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc_next = 32'(32'h30 + 4 * i);
      in_instruction = 32'h1111_0000 + 32'(i);
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    in_pc_next = 32'h40;
    in_instruction = 32'h2222_0000;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc_en", 32'(pc_en), 32'd1);
    in_valid = 1'b1;
    in_pc_next = 32'h100;
    in_instruction = 32'h3333_0000;
    out_ready = 1'b0;
    step();
    chk("redirect_pc", out_pc_next, 32'h100);
    chk("redirect_count", 32'(count), 32'd1);

    // Mid-run reset
    in_pc_next = 32'h104;
    in_instruction = 32'h3333_0001;
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b0;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc_next, 32'h0);
    chk("rst_ins", out_instruction, 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_pc_en", 32'(pc_en), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc_next = $urandom;
      in_instruction = $urandom;
      step();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
